paint_arbiter: RTL and testbench

PAINT_ARBITER -- requirements
Module: paint_arbiter

---
 rtl/paint_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_paint_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paint_arbiter.sv
// Arbitrates board-clear, piece-move and single-cell paint jobs onto one cell painter.
// Each job becomes one or more kick/done handshakes with the painter, in the fixed priority clear > move > cell.
module paint_arbiter #(
    parameter int         COLS           = 10,
    parameter int         ROWS           = 20,
    parameter logic [8:0] PIECE_COLOR    = 9'h1C7,
    parameter logic [8:0] BG_COLOR       = 9'h1FF,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       clear_req,
    input  logic       move_req,
    input  logic [3:0] old_x,
    input  logic [4:0] old_y,
    input  logic [3:0] new_x,
    input  logic [4:0] new_y,
    input  logic       cell_req,
    input  logic [3:0] cell_x,
    input  logic [4:0] cell_y,
    input  logic [8:0] cell_color,
    input  logic       done,
    input  logic       busy,
    output logic       kick,
    output logic [9:0] x0,
    output logic [8:0] y0,
    output logic [8:0] paint_color,
    output logic       clear_busy,
    output logic       move_ack,
    output logic       cell_ack,
    output logic       idle
);

    localparam logic [4:0] COLS_L = 5'(COLS);
    localparam logic [5:0] ROWS_L = 6'(ROWS);
    localparam logic [3:0] LAST_X = 4'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    typedef enum logic [3:0] {
        IDLE, CLR_ISSUE, CLR_WAIT, ER_ISSUE, ER_WAIT,
        DR_ISSUE, DR_WAIT, CL_ISSUE, CL_WAIT
    } state_t;

    state_t     state;
    logic       clr_p, mv_p, cell_p;
    logic [3:0] mv_ox, mv_nx, act_nx, cl_x, sx;
    logic [4:0] mv_oy, mv_ny, act_ny, cl_y, sy;
    logic [8:0] cl_c;

    function automatic logic [9:0] map_x(input logic [3:0] cx);
        return {cx, 6'b0};
    endfunction

    // cy*24 as cy*16 + cy*8
    function automatic logic [8:0] map_y(input logic [4:0] cy);
        logic [8:0] t;
        t = {4'b0, cy};
        return (t << 4) + (t << 3);
    endfunction

    function automatic logic on_board(input logic [3:0] cx, input logic [4:0] cy);
        return ({1'b0, cx} < COLS_L) && ({1'b0, cy} < ROWS_L);
    endfunction

    logic in_idle, take_clr, take_mv, take_cell, clr_active, issuing;
    logic mv_coal, mv_ok, cell_ok;

    assign in_idle    = (state == IDLE);
    assign take_clr   = in_idle & clr_p;
    assign take_mv    = in_idle & ~clr_p & mv_p;
    assign take_cell  = in_idle & ~clr_p & ~mv_p & cell_p;
    assign clr_active = (state == CLR_ISSUE) || (state == CLR_WAIT);
    assign issuing    = (state == CLR_ISSUE) || (state == ER_ISSUE) ||
                        (state == DR_ISSUE)  || (state == CL_ISSUE);

    // A move arriving while another is still queued only retargets its destination.
    assign mv_coal = mv_p & ~take_mv;
    assign mv_ok   = on_board(new_x, new_y) & (mv_coal | on_board(old_x, old_y));
    assign cell_ok = on_board(cell_x, cell_y);

    assign kick       = issuing & ~busy;
    assign clear_busy = clr_p | clr_active;
    assign idle       = ~clear_busy & ~mv_p & ~cell_p & in_idle;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            clr_p       <= CLEAR_ON_RESET;
            mv_p        <= 1'b0;
            cell_p      <= 1'b0;
            move_ack    <= 1'b0;
            cell_ack    <= 1'b0;
            x0          <= '0;
            y0          <= '0;
            paint_color <= '0;
            sx          <= '0;
            sy          <= '0;
        end else begin
            move_ack <= 1'b0;
            cell_ack <= 1'b0;

            if (clear_req && !clr_active) clr_p <= 1'b1;
            else if (take_clr)            clr_p <= 1'b0;

            if (move_req && mv_ok) begin
                mv_p  <= 1'b1;
                mv_nx <= new_x;
                mv_ny <= new_y;
                if (!mv_coal) begin
                    mv_ox <= old_x;
                    mv_oy <= old_y;
                end
            end else if (take_mv) begin
                mv_p <= 1'b0;
            end

            if (cell_req && cell_ok) begin
                cell_p <= 1'b1;
                cl_x   <= cell_x;
                cl_y   <= cell_y;
                cl_c   <= cell_color;
            end else if (take_cell) begin
                cell_p <= 1'b0;
            end

            // Painter command registers are loaded on entry to each ISSUE state and held through WAIT.
            case (state)
                IDLE: begin
                    if (take_clr) begin
                        sx          <= '0;
                        sy          <= '0;
                        x0          <= '0;
                        y0          <= '0;
                        paint_color <= BG_COLOR;
                        state       <= CLR_ISSUE;
                    end else if (take_mv) begin
                        act_nx <= mv_nx;
                        act_ny <= mv_ny;
                        if (mv_ox == mv_nx && mv_oy == mv_ny) begin
                            x0          <= map_x(mv_nx);
                            y0          <= map_y(mv_ny);
                            paint_color <= PIECE_COLOR;
                            state       <= DR_ISSUE;
                        end else begin
                            x0          <= map_x(mv_ox);
                            y0          <= map_y(mv_oy);
                            paint_color <= BG_COLOR;
                            state       <= ER_ISSUE;
                        end
                    end else if (take_cell) begin
                        x0          <= map_x(cl_x);
                        y0          <= map_y(cl_y);
                        paint_color <= cl_c;
                        state       <= CL_ISSUE;
                    end
                end
                CLR_ISSUE: if (!busy) state <= CLR_WAIT;
                CLR_WAIT: begin
                    if (done) begin
                        if (sx == LAST_X) begin
                            sx <= '0;
                            if (sy == LAST_Y) begin
                                state <= IDLE;
                            end else begin
                                sy    <= sy + 5'd1;
                                x0    <= '0;
                                y0    <= map_y(sy + 5'd1);
                                state <= CLR_ISSUE;
                            end
                        end else begin
                            sx    <= sx + 4'd1;
                            x0    <= map_x(sx + 4'd1);
                            state <= CLR_ISSUE;
                        end
                    end
                end
                ER_ISSUE: if (!busy) state <= ER_WAIT;
                ER_WAIT: begin
                    if (done) begin
                        x0          <= map_x(act_nx);
                        y0          <= map_y(act_ny);
                        paint_color <= PIECE_COLOR;
                        state       <= DR_ISSUE;
                    end
                end
                DR_ISSUE: if (!busy) state <= DR_WAIT;
                DR_WAIT: begin
                    if (done) begin
                        move_ack <= 1'b1;
                        state    <= IDLE;
                    end
                end
                CL_ISSUE: if (!busy) state <= CL_WAIT;
                CL_WAIT: begin
                    if (done) begin
                        cell_ack <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paint_arbiter.sv
// Directed bench for paint_arbiter: a model painter (busy 3 cycles, then done) logs every kick,
// and each scenario compares the kick log and ack counts against hand-computed values.
module tb_paint_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       reset, clear_req, move_req, cell_req, done, busy;
    logic [3:0] old_x, new_x, cell_x;
    logic [4:0] old_y, new_y, cell_y;
    logic [8:0] cell_color;
    logic       kick, clear_busy, move_ack, cell_ack, idle;
    logic [9:0] x0;
    logic [8:0] y0, paint_color;

    int          nvec = 0, nmis = 0;
    int          n_mack = 0, n_cack = 0, n_viol = 0, pcnt = 0;
    logic        kick_s = 1'b0;
    logic [31:0] kq[$];

    paint_arbiter dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .clear_req(clear_req),
        .move_req(move_req), .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
        .cell_req(cell_req), .cell_x(cell_x), .cell_y(cell_y), .cell_color(cell_color),
        .done(done), .busy(busy), .kick(kick), .x0(x0), .y0(y0), .paint_color(paint_color),
        .clear_busy(clear_busy), .move_ack(move_ack), .cell_ack(cell_ack), .idle(idle)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic [9:0] x, input logic [8:0] y, input logic [8:0] c);
        return {4'b0, x, y, c};
    endfunction

    // Monitor: log kicks and acks mid-cycle
    always @(negedge CLOCK_50) begin
        kick_s = kick;
        if (kick === 1'b1) begin
            kq.push_back(ent(x0, y0, paint_color));
            if (busy) n_viol++;
        end
        if (move_ack === 1'b1) n_mack++;
        if (cell_ack === 1'b1) n_cack++;
    end

    // Painter model: busy for 3 cycles after a kick, then a one-cycle done
    always @(posedge CLOCK_50) begin
        #1;
        done = 1'b0;
        if (busy) begin
            pcnt--;
            if (pcnt == 0) begin
                busy = 1'b0;
                done = 1'b1;
            end
        end else if (kick_s) begin
            busy = 1'b1;
            pcnt = 3;
        end
    end

    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic clr_log();
        kq.delete();
        n_mack = 0;
        n_cack = 0;
    endtask

    task automatic move_pulse(input logic [3:0] ox, input logic [4:0] oy,
                              input logic [3:0] nx, input logic [4:0] ny);
        old_x = ox; old_y = oy; new_x = nx; new_y = ny;
        move_req = 1'b1;
        step();
        move_req = 1'b0;
    endtask

    task automatic cell_pulse(input logic [3:0] cx, input logic [4:0] cy, input logic [8:0] c);
        cell_x = cx; cell_y = cy; cell_color = c;
        cell_req = 1'b1;
        step();
        cell_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        repeat (2) step();
        for (int i = 0; i < budget; i++) begin
            if (idle && !busy) break;
            step();
        end
        step();
        chk({tag, "_idle"}, 32'(idle), 1);
    endtask

    task automatic wait_kicks(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (kq.size() >= n) break;
            step();
        end
        chk({tag, "_kicks"}, 32'(kq.size() >= n), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear_req = 1'b0; move_req = 1'b0; cell_req = 1'b0;
        old_x = '0; old_y = '0; new_x = '0; new_y = '0;
        cell_x = '0; cell_y = '0; cell_color = '0;
        busy = 1'b0; done = 1'b0;
        repeat (3) step();

        chk("rst_kick", 32'(kick), 0);
        chk("rst_x0", 32'(x0), 0);
        chk("rst_y0", 32'(y0), 0);
        chk("rst_color", 32'(paint_color), 0);
        chk("rst_acks", 32'({move_ack, cell_ack}), 0);
        chk("rst_clear_busy", 32'(clear_busy), 1);
        chk("rst_idle", 32'(idle), 0);

        // Power-on clear sweep
        clr_log();
        reset = 1'b0;
        wait_idle("boot", 5000);
        chk("boot_count", 32'(kq.size()), 200);
        chk("boot_first", kq[0], ent(10'd0, 9'd0, 9'h1FF));
        chk("boot_row1", kq[10], ent(10'd0, 9'd24, 9'h1FF));
        chk("boot_last", kq[199], ent(10'd576, 9'd456, 9'h1FF));
        chk("boot_clear_busy", 32'(clear_busy), 0);

        // Off-board requests are dropped
        clr_log();
        cell_pulse(4'd10, 5'd5, 9'h055);
        move_pulse(4'd1, 5'd1, 4'd1, 5'd20);
        repeat (20) step();
        chk("drop_kicks", 32'(kq.size()), 0);
        chk("drop_acks", 32'(n_mack + n_cack), 0);
        chk("drop_idle", 32'(idle), 1);

        // Basic move (2,3)->(2,4)
        clr_log();
        move_pulse(4'd2, 5'd3, 4'd2, 5'd4);
        wait_idle("move", 200);
        chk("move_count", 32'(kq.size()), 2);
        chk("move_erase", kq[0], ent(10'd128, 9'd72, 9'h1FF));
        chk("move_draw", kq[1], ent(10'd128, 9'd96, 9'h1C7));
        chk("move_ack", 32'(n_mack), 1);

        // old == new skips the erase
        clr_log();
        move_pulse(4'd5, 5'd5, 4'd5, 5'd5);
        wait_idle("same", 200);
        chk("same_count", 32'(kq.size()), 1);
        chk("same_draw", kq[0], ent(10'd320, 9'd120, 9'h1C7));
        chk("same_ack", 32'(n_mack), 1);

        // Single cell paint
        clr_log();
        cell_pulse(4'd3, 5'd7, 9'h0AB);
        wait_idle("cell", 200);
        chk("cell_count", 32'(kq.size()), 1);
        chk("cell_kick", kq[0], ent(10'd192, 9'd168, 9'h0AB));
        chk("cell_ack", 32'(n_cack), 1);

        // Simultaneous clear, move and cell
        clr_log();
        clear_req = 1'b1;
        old_x = 4'd1; old_y = 5'd1; new_x = 4'd1; new_y = 5'd2; move_req = 1'b1;
        cell_x = 4'd4; cell_y = 5'd4; cell_color = 9'h123; cell_req = 1'b1;
        step();
        clear_req = 1'b0; move_req = 1'b0; cell_req = 1'b0;
        wait_idle("prio", 5000);
        chk("prio_count", 32'(kq.size()), 203);
        chk("prio_clr_first", kq[0], ent(10'd0, 9'd0, 9'h1FF));
        chk("prio_clr_last", kq[199], ent(10'd576, 9'd456, 9'h1FF));
        chk("prio_erase", kq[200], ent(10'd64, 9'd24, 9'h1FF));
        chk("prio_draw", kq[201], ent(10'd64, 9'd48, 9'h1C7));
        chk("prio_cell", kq[202], ent(10'd256, 9'd96, 9'h123));
        chk("prio_acks", 32'({8'(n_mack), 8'(n_cack)}), 32'h0101);

        // Moves arriving during an erase coalesce into one further move
        clr_log();
        move_pulse(4'd0, 5'd0, 4'd1, 5'd0);
        wait_kicks("coal", 1, 50);
        old_x = 4'd1; old_y = 5'd0; new_x = 4'd2; new_y = 5'd0; move_req = 1'b1;
        step();
        old_x = 4'd2; old_y = 5'd0; new_x = 4'd3; new_y = 5'd0;
        step();
        move_req = 1'b0;
        wait_idle("coal", 400);
        chk("coal_count", 32'(kq.size()), 4);
        chk("coal_draw1", kq[1], ent(10'd64, 9'd0, 9'h1C7));
        chk("coal_erase2", kq[2], ent(10'd64, 9'd0, 9'h1FF));
        chk("coal_draw2", kq[3], ent(10'd192, 9'd0, 9'h1C7));
        chk("coal_acks", 32'(n_mack), 2);

        // Pending cell is last-wins while a move is in flight
        clr_log();
        move_pulse(4'd6, 5'd6, 4'd6, 5'd7);
        wait_kicks("lw", 1, 50);
        cell_pulse(4'd1, 5'd1, 9'h001);
        cell_pulse(4'd2, 5'd2, 9'h002);
        wait_idle("lw", 400);
        chk("lw_count", 32'(kq.size()), 3);
        chk("lw_draw", kq[1], ent(10'd384, 9'd168, 9'h1C7));
        chk("lw_cell", kq[2], ent(10'd128, 9'd48, 9'h002));
        chk("lw_ack", 32'(n_cack), 1);

        // A move_req in the cycle its pending move is consumed is kept
        clr_log();
        old_x = 4'd0; old_y = 5'd1; new_x = 4'd0; new_y = 5'd2; move_req = 1'b1;
        step();
        old_x = 4'd0; old_y = 5'd3; new_x = 4'd0; new_y = 5'd4;
        step();
        move_req = 1'b0;
        wait_idle("b2b", 400);
        chk("b2b_count", 32'(kq.size()), 4);
        chk("b2b_first", kq[0], ent(10'd0, 9'd24, 9'h1FF));
        chk("b2b_erase2", kq[2], ent(10'd0, 9'd72, 9'h1FF));
        chk("b2b_draw2", kq[3], ent(10'd0, 9'd96, 9'h1C7));
        chk("b2b_acks", 32'(n_mack), 2);

        // Reset while the draw is in flight abandons the move
        clr_log();
        move_pulse(4'd8, 5'd8, 4'd8, 5'd9);
        wait_kicks("rdw", 2, 50);
        chk("rdw_draw", kq[1], ent(10'd512, 9'd216, 9'h1C7));
        step();
        reset = 1'b1;
        step();
        chk("rdw_kick", 32'(kick), 0);
        chk("rdw_cmd", 32'({x0, y0, paint_color}), 0);
        chk("rdw_move_ack", 32'(move_ack), 0);
        chk("rdw_idle", 32'(idle), 0);
        reset = 1'b0;
        wait_idle("rdw", 5000);
        chk("rdw_no_ack", 32'(n_mack), 0);
        chk("rdw_count", 32'(kq.size()), 202);
        chk("rdw_clr_first", kq[2], ent(10'd0, 9'd0, 9'h1FF));

        chk("no_kick_while_busy", 32'(n_viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
